// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad matrix scanner: debounced press/release, column scan, key encode.
// Optional multi-key/ghost rejection enabled by defining KEYPAD_GHOST_REJECT_EN.
module keypad_matrix_scan #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int SETTLE_CNT   = 50
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] ROW_IN,
    output logic [3:0] COL_OUT,
    output logic [3:0] KEY_CODE,
    output logic       KEY_PRESS,
    output logic       KEY_RELEASE,
    output logic       KEY_HELD
);
    // state        | meaning
    // S_IDLE       | no key down, columns all driven low
    // S_FILTER     | some row low, waiting for stable press
    // S_SCAN       | walking one low column at a time to locate the key
    // S_PRESSED    | key accepted (or suppressed ghost), waiting for release
    // S_REL_FILTER | all rows high, waiting for stable release
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILTER     = 3'd1,
        S_SCAN       = 3'd2,
        S_PRESSED    = 3'd3,
        S_REL_FILTER = 3'd4
    } state_t;

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CNT - 1);
    localparam logic [19:0] SET_LAST = 20'(SETTLE_CNT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_row_m, r_row_s;
    logic [19:0] r_cnt;
    logic [1:0]  r_col;
    logic        r_hit;
    logic [3:0]  r_hit_code;
    logic [3:0]  r_key_code;
    logic        r_key_press, r_key_release, r_key_held;

    logic        w_any_low, w_settled, w_col_hit, w_scan_done;
    logic        w_press, w_release, w_illegal;
    logic [3:0]  w_low, w_code_final;
    logic [1:0]  w_row_idx;
    logic        w_ghost, w_suppress;

    assign w_low       = ~r_row_s;
    assign w_any_low   = (r_row_s != 4'b1111);
    assign w_settled   = (r_cnt == SET_LAST);
    assign w_col_hit   = |w_low;
    assign w_scan_done = (r_state == S_SCAN) && w_settled && (r_col == 2'd3);

    // lowest row index wins within a column
    always_comb begin
        w_row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_low[i]) w_row_idx = 2'(i);
        end
    end

    assign w_code_final = r_hit ? r_hit_code : {w_row_idx, r_col};

`ifdef KEYPAD_GHOST_REJECT_EN
    logic r_multi, r_suppress;
    assign w_ghost    = r_multi | ((w_low & (w_low - 4'd1)) != 4'd0) | (r_hit & w_col_hit);
    assign w_suppress = r_suppress;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_multi    <= 1'b0;
            r_suppress <= 1'b0;
        end else begin
            if (r_state != S_SCAN) r_multi <= 1'b0;
            else if (w_settled)    r_multi <= w_ghost;
            if (w_scan_done) r_suppress <= w_ghost;
        end
    end
`else
    assign w_ghost    = 1'b0;
    assign w_suppress = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:       if (w_any_low) w_next = S_FILTER;
            S_FILTER: begin
                if (!w_any_low)             w_next = S_IDLE;
                else if (r_cnt == DEB_LAST) w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_scan_done) begin
                    if (r_hit || w_col_hit) begin
                        w_next  = S_PRESSED;
                        w_press = !w_ghost;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_PRESSED:    if (!w_any_low) w_next = S_REL_FILTER;
            S_REL_FILTER: begin
                if (w_any_low) begin
                    w_next = S_PRESSED;
                end else if (r_cnt == DEB_LAST) begin
                    w_next    = S_IDLE;
                    w_release = !w_suppress;
                end
            end
            default: begin
                w_next    = S_IDLE;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= S_IDLE;
            r_row_m       <= 4'b1111;
            r_row_s       <= 4'b1111;
            r_cnt         <= '0;
            r_col         <= '0;
            r_hit         <= 1'b0;
            r_hit_code    <= '0;
            r_key_code    <= '0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
        end else begin
            r_row_m <= ROW_IN;
            r_row_s <= r_row_m;
            r_state <= w_next;

            if ((w_next != r_state) || ((r_state == S_SCAN) && w_settled)) r_cnt <= '0;
            else                                                         r_cnt <= r_cnt + 20'd1;

            if (r_state != S_SCAN) begin
                r_col <= 2'd0;
                r_hit <= 1'b0;
            end else if (w_settled) begin
                r_col <= r_col + 2'd1;
                if (!r_hit && w_col_hit) begin
                    r_hit      <= 1'b1;
                    r_hit_code <= {w_row_idx, r_col};
                end
            end

            r_key_press   <= w_press;
            r_key_release <= w_release;
            if (w_press) begin
                r_key_code <= w_code_final;
                r_key_held <= 1'b1;
            end
            if (w_release) r_key_held <= 1'b0;
            if (w_illegal) begin
                r_key_code <= '0;
                r_key_held <= 1'b0;
            end
        end
    end

    assign COL_OUT     = (r_state == S_SCAN) ? ~(4'b0001 << r_col) : 4'b0000;
    assign KEY_CODE    = r_key_code;
    assign KEY_PRESS   = r_key_press;
    assign KEY_RELEASE = r_key_release;
    assign KEY_HELD    = r_key_held;
endmodule
